// File: rtl/cmp_search_ctrl.sv
// cmp_search_ctrl: binary-search controller that drives the A operand of an
// external magnitude comparator and consumes its 3-bit relation code
// ([2]=guess>secret, [1]=equal, [0]=guess<secret) to locate the secret B operand.
// CMP_LAT sets how many extra cycles each evaluation waits for the comparator.
// Optional feature macro: SEARCH_STEPCNT_EN adds the oSteps evaluation counter output.
module cmp_search_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CMP_LAT = 0
) (
  input  logic                            iClk,
  input  logic                            iRst,
  input  logic                            iStart,
  input  logic [2:0]                      iCmp,
  output logic [WIDTH-1:0]                oGuess,
  output logic                            oBusy,
  output logic                            oDone,
  output logic                            oErr,
  output logic [WIDTH-1:0]                oResult
`ifdef SEARCH_STEPCNT_EN
  ,
  output logic [$clog2(WIDTH+2)-1:0]      oSteps
`endif
);

  localparam int CW = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] guess_dec;
  logic [WIDTH-1:0] guess_inc;

  // Midpoint with a WIDTH+1-bit sum so lo+hi cannot overflow; rounds down.
  function automatic logic [WIDTH-1:0] mid(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] h);
    logic [WIDTH:0] s;
    s = {1'b0, l} + {1'b0, h};
    return s[WIDTH:1];
  endfunction

  // Neighbours of the current guess used when the range shrinks.
  always_comb begin
    guess_dec = oGuess - WIDTH'(1);
    guess_inc = oGuess + WIDTH'(1);
  end

  // Status flags are pure decodes of the state register.
  always_comb begin
    oBusy = (state == WAIT);
    oDone = (state == DONE);
  end

  // Search sequencer: start, wait for the comparator, narrow the range, finish.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state   <= IDLE;
      lo      <= '0;
      hi      <= '0;
      cnt     <= '0;
      oGuess  <= '0;
      oErr    <= 1'b0;
      oResult <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (iStart) begin
            lo     <= '0;
            hi     <= '1;
            oGuess <= mid('0, '1);
            cnt    <= CW'(CMP_LAT);
            oErr   <= 1'b0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            case (iCmp)
              3'b010: begin
                oResult <= oGuess;
                state   <= DONE;
              end
              3'b100: begin
                // Guess too high; an empty remaining range means the answers were inconsistent.
                if (oGuess == lo) begin
                  oErr  <= 1'b1;
                  state <= DONE;
                end else begin
                  hi     <= guess_dec;
                  oGuess <= mid(lo, guess_dec);
                  cnt    <= CW'(CMP_LAT);
                end
              end
              3'b001: begin
                if (oGuess == hi) begin
                  oErr  <= 1'b1;
                  state <= DONE;
                end else begin
                  lo     <= guess_inc;
                  oGuess <= mid(guess_inc, hi);
                  cnt    <= CW'(CMP_LAT);
                end
              end
              default: begin
                oErr  <= 1'b1;
                state <= DONE;
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEARCH_STEPCNT_EN
  localparam int SW = $clog2(WIDTH + 2);

  // Evaluation counter: cleared on an accepted start, bumped on every evaluated code.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oSteps <= '0;
    end else if ((state == IDLE || state == DONE) && iStart) begin
      oSteps <= '0;
    end else if (state == WAIT && cnt == '0) begin
      oSteps <= oSteps + SW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Bench for cmp_search_ctrl: one combinational-comparator instance (CMP_LAT=0)
// and one pipelined-comparator instance (CMP_LAT=2), checked against a
// reference binary-search model of the expected guess sequence and outcome.
module tb_cmp_search_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0;
  logic       start2 = 1'b0;
  logic [2:0] cmp0;
  logic [2:0] cmp2;
  logic [2:0] p1, p2;
  int         secret = 0;
  bit         frc_en = 1'b0;
  logic [2:0] frc_code = 3'b000;

  logic [7:0] guess0, result0, guess2, result2;
  logic       busy0, done0, err0, busy2, done2, err2;
`ifdef SEARCH_STEPCNT_EN
  logic [3:0] steps0, steps2;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_seq[$];
  bit exp_err;
  int exp_res;

  always #5 clk = ~clk;

  cmp_search_ctrl #(.WIDTH(8), .CMP_LAT(0)) u_lat0 (
    .iClk(clk), .iRst(rst), .iStart(start0), .iCmp(cmp0),
    .oGuess(guess0), .oBusy(busy0), .oDone(done0), .oErr(err0), .oResult(result0)
`ifdef SEARCH_STEPCNT_EN
    , .oSteps(steps0)
`endif
  );

  cmp_search_ctrl #(.WIDTH(8), .CMP_LAT(2)) u_lat2 (
    .iClk(clk), .iRst(rst), .iStart(start2), .iCmp(cmp2),
    .oGuess(guess2), .oBusy(busy2), .oDone(done2), .oErr(err2), .oResult(result2)
`ifdef SEARCH_STEPCNT_EN
    , .oSteps(steps2)
`endif
  );

  function automatic logic [2:0] code_of(input int g, input int s);
    if (g > s)       return 3'b100;
    else if (g == s) return 3'b010;
    else             return 3'b001;
  endfunction

  // Comparator models: combinational for u_lat0, two-stage pipeline for u_lat2.
  always_comb cmp0 = frc_en ? frc_code : code_of(int'(guess0), secret);
  always @(posedge clk) begin
    p1 <= frc_en ? frc_code : code_of(int'(guess2), secret);
    p2 <= p1;
  end
  always_comb cmp2 = p2;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference search: plain integer bisection over [0,255] answered by the oracle.
  task automatic model(input int s, input bit frc, input logic [2:0] fc);
    int lo, hi, g;
    logic [2:0] c;
    exp_seq.delete();
    exp_err = 1'b0;
    exp_res = -1;
    lo = 0;
    hi = 255;
    for (int it = 0; it < 20; it++) begin
      g = (lo + hi) / 2;
      exp_seq.push_back(g);
      c = frc ? fc : code_of(g, s);
      if (c == 3'b010) begin
        exp_res = g;
        break;
      end else if (c == 3'b100) begin
        if (g == lo) begin exp_err = 1'b1; break; end
        hi = g - 1;
      end else if (c == 3'b001) begin
        if (g == hi) begin exp_err = 1'b1; break; end
        lo = g + 1;
      end else begin
        exp_err = 1'b1;
        break;
      end
    end
  endtask

  task automatic sample(input bit which, output int g, output int b, output int d,
                        output int e, output int r, output int st);
    g  = which ? int'(guess2)  : int'(guess0);
    b  = which ? int'(busy2)   : int'(busy0);
    d  = which ? int'(done2)   : int'(done0);
    e  = which ? int'(err2)    : int'(err0);
    r  = which ? int'(result2) : int'(result0);
`ifdef SEARCH_STEPCNT_EN
    st = which ? int'(steps2) : int'(steps0);
`else
    st = 0;
`endif
  endtask

  task automatic set_start(input bit which, input logic v);
    if (which) start2 = v;
    else       start0 = v;
  endtask

  // Runs one search and checks every cycle from acceptance through DONE.
  task automatic run(input bit which, input int s, input bit frc, input logic [2:0] fc,
                     input bit start_in_wait);
    int lat, g, b, d, e, r, st;
    lat = which ? 2 : 0;
    model(s, frc, fc);
    @(negedge clk);
    secret   = s;
    frc_en   = frc;
    frc_code = fc;
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, start_in_wait);
    sample(which, g, b, d, e, r, st);
    chk("done_cleared", d, 0);
    chk("err_cleared", e, 0);
    for (int k = 0; k < exp_seq.size(); k++) begin
      for (int c = 0; c <= lat; c++) begin
        sample(which, g, b, d, e, r, st);
        chk("busy_wait", b, 1);
        chk("done_wait", d, 0);
        chk("guess", g, exp_seq[k]);
        @(negedge clk);
      end
    end
    set_start(which, 1'b0);
    sample(which, g, b, d, e, r, st);
    chk("done", d, 1);
    chk("busy_done", b, 0);
    chk("err", e, int'(exp_err));
    if (!exp_err) chk("result", r, exp_res);
    chk("guess_final", g, exp_seq[exp_seq.size()-1]);
`ifdef SEARCH_STEPCNT_EN
    chk("steps", st, exp_seq.size());
`endif
    @(negedge clk);
    sample(which, g, b, d, e, r, st);
    chk("done_held", d, 1);
    chk("guess_held", g, exp_seq[exp_seq.size()-1]);
    frc_en = 1'b0;
  endtask

  initial begin
    int g, b, d, e, r, st;
    int t2[8] = '{127, 63, 31, 15, 7, 3, 1, 0};
    int t3[9] = '{127, 191, 223, 239, 247, 251, 253, 254, 255};

    // Reset state of both instances.
    #1;
    for (int w = 0; w < 2; w++) begin
      sample(w[0], g, b, d, e, r, st);
      chk("rst_guess", g, 0);
      chk("rst_busy", b, 0);
      chk("rst_done", d, 0);
      chk("rst_err", e, 0);
      chk("rst_result", r, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Pin the model against hand-derived sequences.
    model(127, 1'b0, 3'b000);
    chk("model_t1_len", exp_seq.size(), 1);
    chk("model_t1_res", exp_res, 127);
    model(0, 1'b0, 3'b000);
    chk("model_t2_len", exp_seq.size(), 8);
    for (int i = 0; i < 8; i++) chk("model_t2_seq", exp_seq[i], t2[i]);
    model(255, 1'b0, 3'b000);
    chk("model_t3_len", exp_seq.size(), 9);
    for (int i = 0; i < 9; i++) chk("model_t3_seq", exp_seq[i], t3[i]);
    model(0, 1'b1, 3'b001);
    chk("model_t5_len", exp_seq.size(), 9);
    chk("model_t5_err", int'(exp_err), 1);

    run(1'b0, 127, 1'b0, 3'b000, 1'b0);
    run(1'b0, 0,   1'b0, 3'b000, 1'b0);
    run(1'b0, 255, 1'b0, 3'b000, 1'b0);
    run(1'b0, 90,  1'b0, 3'b000, 1'b1);
    run(1'b1, 200, 1'b0, 3'b000, 1'b0);
    run(1'b1, 1,   1'b0, 3'b000, 1'b1);
    run(1'b0, 50,  1'b1, 3'b011, 1'b0);
    run(1'b0, 50,  1'b1, 3'b001, 1'b0);
    run(1'b0, 50,  1'b1, 3'b100, 1'b0);
    run(1'b0, 50,  1'b1, 3'b000, 1'b0);
    // Normal search directly after an error DONE must clear the flags.
    run(1'b0, 77,  1'b0, 3'b000, 1'b0);

    // Asynchronous reset in the middle of a pipelined search.
    @(negedge clk);
    secret = 200;
    start2 = 1'b1;
    repeat (4) @(negedge clk);
    sample(1'b1, g, b, d, e, r, st);
    chk("mid_busy", b, 1);
    #2 rst = 1'b1;
    #1;
    sample(1'b1, g, b, d, e, r, st);
    chk("arst_guess", g, 0);
    chk("arst_busy", b, 0);
    chk("arst_done", d, 0);
    chk("arst_err", e, 0);
    chk("arst_result", r, 0);
    start2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sample(1'b1, g, b, d, e, r, st);
    chk("idle_after_rst", b + d, 0);
    run(1'b1, 200, 1'b0, 3'b000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
